// File: rtl/vmem_rect_fill_pkg.sv
// Shared constants for the rectangle-fill engine: vmem geometry, register map,
// CTRL bit positions and FSM state encoding.
package vmem_rect_fill_pkg;

  localparam int VMEM_ROW_W = 8;
  localparam int VMEM_COL_W = 8;

  localparam logic [3:0] ADDR_CTRL  = 4'h0;
  localparam logic [3:0] ADDR_P0    = 4'h4;
  localparam logic [3:0] ADDR_P1    = 4'h8;
  localparam logic [3:0] ADDR_COLOR = 4'hC;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vmem_rect_fill_if.sv
// Register bus, CPU vmem write path, vmem write port and status lines of the fill engine.
// master = CPU/system side, slave = engine.
interface vmem_rect_fill_if #(parameter int COLOR_W = 3);

  logic               reg_we_i;
  logic [3:0]         reg_addr_i;
  logic [31:0]        reg_wdata_i;
  logic [31:0]        reg_rdata_o;
  logic               cpu_vmem_we_i;
  logic [15:0]        cpu_vmem_addr_i;
  logic [COLOR_W-1:0] cpu_vmem_wdata_i;
  logic               vmem_we_o;
  logic [15:0]        vmem_waddr_o;
  logic [COLOR_W-1:0] vmem_wdata_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output reg_we_i, reg_addr_i, reg_wdata_i,
    output cpu_vmem_we_i, cpu_vmem_addr_i, cpu_vmem_wdata_i,
    input  reg_rdata_o, vmem_we_o, vmem_waddr_o, vmem_wdata_o, busy_o, done_o
  );

  modport slave (
    input  reg_we_i, reg_addr_i, reg_wdata_i,
    input  cpu_vmem_we_i, cpu_vmem_addr_i, cpu_vmem_wdata_i,
    output reg_rdata_o, vmem_we_o, vmem_waddr_o, vmem_wdata_o, busy_o, done_o
  );

endinterface

// File: rtl/vmem_rect_fill_rect_scan_ctr.sv
// Raster scan counter: walks x from x0 to x1c, then wraps to the next row until (x1c, y1c).
// Bounds are latched on load so the engine is immune to later register writes.
module rect_scan_ctr
  import vmem_rect_fill_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load,
  input  logic                  step,
  input  logic [VMEM_COL_W-1:0] x0,
  input  logic [VMEM_ROW_W-1:0] y0,
  input  logic [VMEM_COL_W-1:0] x1c,
  input  logic [VMEM_ROW_W-1:0] y1c,
  output logic [VMEM_COL_W-1:0] x,
  output logic [VMEM_ROW_W-1:0] y,
  output logic                  last
);

  logic [VMEM_COL_W-1:0] x_q, x0_q, x1c_q;
  logic [VMEM_ROW_W-1:0] y_q, y1c_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      y_q   <= '0;
      x0_q  <= '0;
      x1c_q <= '0;
      y1c_q <= '0;
    end else if (load) begin
      x_q   <= x0;
      y_q   <= y0;
      x0_q  <= x0;
      x1c_q <= x1c;
      y1c_q <= y1c;
    end else if (step) begin
      if (x_q == x1c_q) begin
        x_q <= x0_q;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == x1c_q) && (y_q == y1c_q);

endmodule

// File: rtl/vmem_rect_fill.sv
// Rectangle-fill engine in front of the vmem write port: register file, sequencing FSM,
// read-back mux and CPU-priority write arbitration.
//   state    | meaning
//   ST_IDLE  | waiting for START; registers writable
//   ST_SETUP | clamp corners, reject empty rectangle, load scan counter
//   ST_FILL  | one pixel per cycle unless the CPU owns the write port
//   ST_DONE  | one-cycle done pulse, sets DONE_STICKY
module vmem_rect_fill
  import vmem_rect_fill_pkg::*;
#(
  parameter int XMAX    = 239,
  parameter int YMAX    = 239,
  parameter int COLOR_W = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  vmem_rect_fill_if.slave bus
);

  localparam logic [VMEM_COL_W-1:0] XMAX_C = VMEM_COL_W'(XMAX);
  localparam logic [VMEM_ROW_W-1:0] YMAX_C = VMEM_ROW_W'(YMAX);

  state_t             state;
  logic [15:0]        p0_q, p1_q;
  logic [COLOR_W-1:0] color_q;
  logic               done_sticky_q, busy_q, done_q;
  logic [31:0]        rdata_q;

  logic ctrl_wr, start_req, abort_req, empty, load, step, last;
  logic [VMEM_COL_W-1:0] x0, x1c, x;
  logic [VMEM_ROW_W-1:0] y0, y1c, y;

  assign ctrl_wr   = bus.reg_we_i && (bus.reg_addr_i == ADDR_CTRL);
  // ABORT dominates START when both arrive in one write.
  assign start_req = ctrl_wr && bus.reg_wdata_i[CTRL_START] && !bus.reg_wdata_i[CTRL_ABORT];
  assign abort_req = ctrl_wr && bus.reg_wdata_i[CTRL_ABORT];

  assign x0  = p0_q[7:0];
  assign y0  = p0_q[15:8];
  assign x1c = (p1_q[7:0]  > XMAX_C) ? XMAX_C : p1_q[7:0];
  assign y1c = (p1_q[15:8] > YMAX_C) ? YMAX_C : p1_q[15:8];

  assign empty = (x0 > x1c) || (y0 > y1c) || (x0 > XMAX_C) || (y0 > YMAX_C);
  assign load  = (state == ST_SETUP) && !abort_req && !empty;
  assign step  = (state == ST_FILL) && !bus.cpu_vmem_we_i && !abort_req;

  rect_scan_ctr u_scan (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load   (load),
    .step   (step),
    .x0     (x0),
    .y0     (y0),
    .x1c    (x1c),
    .y1c    (y1c),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p0_q          <= '0;
      p1_q          <= '0;
      color_q       <= '0;
      done_sticky_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      if (bus.reg_we_i && (state == ST_IDLE)) begin
        case (bus.reg_addr_i)
          ADDR_P0:    p0_q    <= bus.reg_wdata_i[15:0];
          ADDR_P1:    p1_q    <= bus.reg_wdata_i[15:0];
          ADDR_COLOR: color_q <= bus.reg_wdata_i[COLOR_W-1:0];
          default: ;
        endcase
      end
      if (state == ST_DONE)
        done_sticky_q <= 1'b1;
      else if (ctrl_wr && bus.reg_wdata_i[CTRL_CLR_DONE])
        done_sticky_q <= 1'b0;
      case (bus.reg_addr_i)
        ADDR_CTRL:  rdata_q <= {29'b0, done_sticky_q, 1'b0, busy_q};
        ADDR_P0:    rdata_q <= {16'b0, p0_q};
        ADDR_P1:    rdata_q <= {16'b0, p1_q};
        ADDR_COLOR: rdata_q <= {{(32-COLOR_W){1'b0}}, color_q};
        default:    rdata_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state  <= ST_SETUP;
            busy_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (abort_req || empty) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (abort_req || (step && last)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.vmem_we_o    = 1'b0;
    bus.vmem_waddr_o = '0;
    bus.vmem_wdata_o = '0;
    if (bus.cpu_vmem_we_i) begin
      bus.vmem_we_o    = 1'b1;
      bus.vmem_waddr_o = bus.cpu_vmem_addr_i;
      bus.vmem_wdata_o = bus.cpu_vmem_wdata_i;
    end else if (step) begin
      bus.vmem_we_o    = 1'b1;
      bus.vmem_waddr_o = {y, x};
      bus.vmem_wdata_o = color_q;
    end
  end

  assign bus.reg_rdata_o = rdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

  logic unused_wdata;
  assign unused_wdata = ^bus.reg_wdata_i[31:16];

endmodule

// File: tb/tb_vmem_rect_fill.sv
// Scoreboard bench for vmem_rect_fill: stimulus pushes expected pixels and done cycles,
// a negedge monitor pops and compares them against what the DUT emits.
module tb_vmem_rect_fill;
  import vmem_rect_fill_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  vmem_rect_fill_if #(.COLOR_W(3)) bus ();

  vmem_rect_fill dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  int          exp_done[$];
  logic [2:0]  exp_color = '0;
  int          pix_seen  = 0;
  int          fwd_seen  = 0;

  function automatic void check(string name, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  // Reference: every pixel of the clamped rectangle in raster order.
  function automatic int model_rect(logic [15:0] p0, logic [15:0] p1);
    int x0 = int'(p0[7:0]);
    int y0 = int'(p0[15:8]);
    int x1 = (int'(p1[7:0])  > 239) ? 239 : int'(p1[7:0]);
    int y1 = (int'(p1[15:8]) > 239) ? 239 : int'(p1[15:8]);
    int cnt = 0;
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) begin
        exp_q.push_back(16'(yy * 256 + xx));
        cnt++;
      end
    return cnt;
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus.vmem_we_o) begin
        if (bus.cpu_vmem_we_i) begin
          check("fwd_addr", bus.vmem_waddr_o, 16'h1234);
          check("fwd_data", bus.vmem_wdata_o, 3'd7);
          fwd_seen++;
        end else if (exp_q.size() == 0) begin
          check("pixel_pending", exp_q.size() != 0, 1);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("pix_addr", bus.vmem_waddr_o, e);
          check("pix_data", bus.vmem_wdata_o, exp_color);
          pix_seen++;
        end
      end
      if (bus.done_o) begin
        if (exp_done.size() == 0) check("done_pending", exp_done.size() != 0, 1);
        else check("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d, output int n);
    @(posedge clk_i); #1;
    bus.reg_we_i    = 1'b1;
    bus.reg_addr_i  = a;
    bus.reg_wdata_i = d;
    n = cyc;
    @(posedge clk_i); #1;
    bus.reg_we_i = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk_i); #1;
    bus.reg_addr_i = a;
    @(posedge clk_i); #1;
    d = bus.reg_rdata_o;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(name, d, exp);
  endtask

  task automatic start_rect(input logic [15:0] p0, input logic [15:0] p1,
                            input logic [2:0] color, input int stall, output int cnt);
    int n;
    reg_write(ADDR_P0, {16'b0, p0}, n);
    reg_write(ADDR_P1, {16'b0, p1}, n);
    reg_write(ADDR_COLOR, {29'b0, color}, n);
    exp_color = color;
    cnt = model_rect(p0, p1);
    reg_write(ADDR_CTRL, 32'h1, n);
    exp_done.push_back(n + 2 + cnt + stall);
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int t = 0; t < budget && exp_done.size() != 0; t++) @(posedge clk_i);
    check({name, "_done_seen"}, exp_done.size(), 0);
    check({name, "_pixels_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int n, cnt, base;
    logic [15:0] p0, p1;
    int x0, y0, w, h;
    bus.reg_we_i = 0; bus.reg_addr_i = 0; bus.reg_wdata_i = 0;
    bus.cpu_vmem_we_i = 0; bus.cpu_vmem_addr_i = 0; bus.cpu_vmem_wdata_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_we", bus.vmem_we_o, 0);
    read_check("rst_ctrl", ADDR_CTRL, 0);
    read_check("rst_p1", ADDR_P1, 0);

    start_rect(16'h0000, 16'h0101, 3'd5, 0, cnt);
    wait_done(cnt + 20, "t1");
    read_check("t1_ctrl", ADDR_CTRL, 32'h4);
    reg_write(ADDR_CTRL, 32'h4, n);
    read_check("clr_ctrl", ADDR_CTRL, 32'h0);

    start_rect(16'hEEEE, 16'hFFFF, 3'd3, 0, cnt);
    check("t2_count", cnt, 4);
    wait_done(cnt + 20, "t2");

    start_rect(16'h0505, 16'h0303, 3'd6, 0, cnt);
    wait_done(20, "t3");

    reg_write(ADDR_CTRL, 32'h3, n);
    check("start_abort_idle", bus.busy_o, 0);
    repeat (4) @(posedge clk_i);

    fwd_seen = 0;
    start_rect(16'h2010, 16'h2019, 3'd4, 3, cnt);
    repeat (3) @(posedge clk_i);
    #1;
    bus.cpu_vmem_we_i = 1; bus.cpu_vmem_addr_i = 16'h1234; bus.cpu_vmem_wdata_i = 3'd7;
    repeat (3) @(posedge clk_i);
    #1 bus.cpu_vmem_we_i = 0;
    wait_done(cnt + 30, "t4");
    check("t4_fwd_count", fwd_seen, 3);

    for (int i = 0; i < 12; i++) begin
      x0 = $urandom_range(0, 250);
      y0 = $urandom_range(0, 250);
      w  = $urandom_range(0, 5);
      h  = $urandom_range(1, 4);
      p0 = 16'(y0 * 256 + x0);
      p1 = 16'(((y0 + h > 255) ? 255 : y0 + h) * 256 +
               ((w == 0 && x0 > 0) ? x0 - 1 : ((x0 + w > 255) ? 255 : x0 + w)));
      start_rect(p0, p1, 3'($urandom_range(0, 7)), 0, cnt);
      wait_done(cnt + 20, "rnd");
    end

    start_rect(16'h0408, 16'h070F, 3'd2, 0, cnt);
    repeat (4) @(posedge clk_i);
    reg_write(ADDR_P0, 32'h0000_0000, n);
    reg_write(ADDR_COLOR, 32'h7, n);
    reg_write(ADDR_CTRL, 32'h1, n);
    wait_done(cnt + 20, "busy_start");
    read_check("busy_p0_kept", ADDR_P0, 32'h0408);
    read_check("busy_color_kept", ADDR_COLOR, 32'h2);

    reg_write(ADDR_CTRL, 32'h4, n);
    base = pix_seen;
    start_rect(16'h0000, 16'hFFFF, 3'd1, 0, cnt);
    check("t5_count", cnt, 57600);
    for (int t = 0; t < 300 && pix_seen < base + 100; t++) @(posedge clk_i);
    check("t5_reached_100", pix_seen >= base + 100, 1);
    @(posedge clk_i); #1;
    exp_q.delete();
    void'(exp_done.pop_back());
    bus.reg_we_i = 1; bus.reg_addr_i = ADDR_CTRL; bus.reg_wdata_i = 32'h2;
    n = cyc;
    @(posedge clk_i); #1;
    bus.reg_we_i = 0;
    exp_done.push_back(n + 1);
    wait_done(10, "t5");
    repeat (3) @(posedge clk_i);
    #1 check("t5_busy", bus.busy_o, 0);
    read_check("t5_ctrl", ADDR_CTRL, 32'h4);
    start_rect(16'h0102, 16'h0203, 3'd6, 0, cnt);
    wait_done(cnt + 20, "t5_restart");

    start_rect(16'h0000, 16'h3030, 3'd1, 0, cnt);
    repeat (10) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    exp_q.delete();
    exp_done.delete();
    #1;
    check("t6_we", bus.vmem_we_o, 0);
    check("t6_busy", bus.busy_o, 0);
    check("t6_done", bus.done_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    read_check("t6_p0", ADDR_P0, 0);
    read_check("t6_p1", ADDR_P1, 0);
    read_check("t6_color", ADDR_COLOR, 0);
    read_check("t6_ctrl", ADDR_CTRL, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
